// File: rtl/compress_handler.sv
// Run-length encoder: pulls bytes from RAM over the DMA read port and emits
// {bitValue, runLen[6:0]} codes, MSB-first, over a valid/ready stream.
module compress_handler #(
  parameter int ADDR_W  = 16,
  parameter int MAX_RUN = 127
) (
  input  logic              clk,
  input  logic              RST,
  input  logic              start,
  input  logic [ADDR_W-1:0] baseAddr,
  input  logic [15:0]       byteCount,
  output logic [ADDR_W-1:0] ramAddress,
  output logic              read_signal,
  input  logic [7:0]        ramDataOut,
  input  logic              doneRead,
  output logic [7:0]        code,
  output logic              code_valid,
  input  logic              code_ready,
  output logic              busy,
  output logic              done,
  output logic [15:0]       codeCount
);

  typedef enum logic [2:0] {IDLE, REQ, WAIT, SCAN, EMIT, FLUSH, FIN} state_t;

  localparam logic [6:0] RUN_LIMIT = 7'(MAX_RUN);

  state_t state, stateNext;

  logic [ADDR_W-1:0] baseLat;
  logic [15:0]       countLat;
  logic [15:0]       byteIdx;
  logic [7:0]        shiftReg;
  logic [2:0]        bitPtr;
  logic              byteEmpty;
  logic              firstBit;
  logic              curBit;
  logic [6:0]        runLen;

  logic scanBit, runBreak, handshake, lastByte;

  assign scanBit   = shiftReg[bitPtr];
  assign runBreak  = !firstBit && ((scanBit != curBit) || (runLen >= RUN_LIMIT));
  assign handshake = code_valid && code_ready;
  assign lastByte  = (byteIdx == countLat - 16'd1);

  always_comb begin
    stateNext = state;
    case (state)
      IDLE:  if (start) stateNext = (byteCount == 16'd0) ? FIN : REQ;
      REQ:   stateNext = WAIT;
      WAIT:  if (doneRead) stateNext = SCAN;
      SCAN: begin
        if (runBreak)             stateNext = EMIT;
        else if (bitPtr == 3'd0)  stateNext = lastByte ? FLUSH : REQ;
      end
      EMIT: begin
        // After the code is taken, resume wherever the bit stream left off.
        if (handshake) begin
          if (!byteEmpty)    stateNext = SCAN;
          else if (lastByte) stateNext = FLUSH;
          else               stateNext = REQ;
        end
      end
      FLUSH: if (handshake) stateNext = FIN;
      FIN:   stateNext = IDLE;
      default: stateNext = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (RST) state <= IDLE;
    else     state <= stateNext;
  end

  always_ff @(posedge clk) begin
    if (RST) begin
      ramAddress  <= '0;
      read_signal <= 1'b0;
      code        <= '0;
      code_valid  <= 1'b0;
      busy        <= 1'b0;
      done        <= 1'b0;
      codeCount   <= '0;
      byteIdx     <= '0;
      byteEmpty   <= 1'b0;
      firstBit    <= 1'b0;
      curBit      <= 1'b0;
      runLen      <= '0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            baseLat   <= baseAddr;
            countLat  <= byteCount;
            byteIdx   <= '0;
            codeCount <= '0;
            busy      <= 1'b1;
            firstBit  <= 1'b1;
          end
        end
        REQ: begin
          ramAddress  <= baseLat + ADDR_W'(byteIdx);
          read_signal <= 1'b1;
        end
        WAIT: begin
          if (doneRead) begin
            shiftReg    <= ramDataOut;
            read_signal <= 1'b0;
            bitPtr      <= 3'd7;
            byteEmpty   <= 1'b0;
          end
        end
        SCAN: begin
          bitPtr    <= bitPtr - 3'd1;
          byteEmpty <= (bitPtr == 3'd0);
          if (firstBit) begin
            curBit   <= scanBit;
            runLen   <= 7'd1;
            firstBit <= 1'b0;
          end else if (runBreak) begin
            code       <= {curBit, runLen};
            code_valid <= 1'b1;
            curBit     <= scanBit;
            runLen     <= 7'd1;
          end else begin
            runLen <= runLen + 7'd1;
          end
          if (stateNext == REQ) byteIdx <= byteIdx + 16'd1;
        end
        EMIT: begin
          if (handshake) begin
            code_valid <= 1'b0;
            codeCount  <= codeCount + 16'd1;
            if (stateNext == REQ) byteIdx <= byteIdx + 16'd1;
          end
        end
        FLUSH: begin
          // First FLUSH cycle loads the closing run; later cycles wait for it to be taken.
          if (!code_valid) begin
            code       <= {curBit, runLen};
            code_valid <= 1'b1;
          end else if (code_ready) begin
            code_valid <= 1'b0;
            codeCount  <= codeCount + 16'd1;
          end
        end
        FIN: begin
          done <= 1'b1;
          busy <= 1'b0;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_compress_handler.sv
// Directed bench for compress_handler: a behavioural DMA responder and code
// consumer run on the falling edge; each task drives one scenario and checks it.
module tb_compress_handler;
  localparam int ADDR_W = 16;

  bit                clk;
  logic              RST;
  logic              start;
  logic [ADDR_W-1:0] baseAddr;
  logic [15:0]       byteCount;
  logic [ADDR_W-1:0] ramAddress;
  logic              read_signal;
  bit   [7:0]        ramDataOut;
  bit                doneRead;
  logic [7:0]        code;
  logic              code_valid;
  bit                code_ready;
  logic              busy;
  logic              done;
  logic [15:0]       codeCount;

  compress_handler #(.ADDR_W(ADDR_W), .MAX_RUN(127)) dut (
    .clk(clk), .RST(RST), .start(start), .baseAddr(baseAddr), .byteCount(byteCount),
    .ramAddress(ramAddress), .read_signal(read_signal), .ramDataOut(ramDataOut),
    .doneRead(doneRead), .code(code), .code_valid(code_valid), .code_ready(code_ready),
    .busy(busy), .done(done), .codeCount(codeCount)
  );

  always #5 clk = ~clk;

  bit [7:0]          mem [256];
  int                dmaLat, dmaCnt, addrErr, addrIdx;
  bit [ADDR_W-1:0]   heldAddr;
  bit [ADDR_W-1:0]   addrLog [64];
  int                stallLen, stallCnt, stableErr, codeIdx;
  bit                prevStall;
  bit [7:0]          prevCode;
  bit [7:0]          codeLog [64];
  int                vectors, miscompares;

  // DMA responder and code consumer, both acting on the falling edge.
  always @(negedge clk) begin
    doneRead = 1'b0;
    if (read_signal === 1'b1) begin
      if (dmaCnt == 0) begin
        heldAddr = ramAddress;
        addrLog[addrIdx % 64] = ramAddress;
        addrIdx++;
      end else if (ramAddress !== heldAddr) begin
        addrErr++;
      end
      if (dmaCnt >= dmaLat) begin
        doneRead   = 1'b1;
        ramDataOut = mem[ramAddress[7:0]];
        dmaCnt     = 0;
      end else begin
        dmaCnt++;
      end
    end else begin
      dmaCnt = 0;
    end

    if (prevStall && (code_valid !== 1'b1 || code !== prevCode)) stableErr++;
    if (code_valid === 1'b1) begin
      code_ready = (stallCnt >= stallLen);
      if (!code_ready) stallCnt++;
    end else begin
      stallCnt   = 0;
      code_ready = (stallLen == 0);
    end
    if (code_valid === 1'b1 && code_ready) begin
      codeLog[codeIdx % 64] = code;
      codeIdx++;
    end
    prevStall = (code_valid === 1'b1) && !code_ready;
    prevCode  = code;
  end

  task automatic do_start(input logic [ADDR_W-1:0] base, input logic [15:0] cnt);
    @(negedge clk);
    start = 1'b1; baseAddr = base; byteCount = cnt;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic wait_done(input string name, input int bound);
    int n = 0;
    while (done !== 1'b1 && n < bound) begin
      @(negedge clk);
      n++;
    end
    vectors++;
    if (done !== 1'b1) begin
      miscompares++;
      $display("FAIL %s done: not seen within %0d cycles", name, bound);
    end
  endtask

  task automatic test_reset();
    RST = 1'b1;
    repeat (3) @(negedge clk);
    vectors++; if (ramAddress !== '0)     begin miscompares++; $display("FAIL reset ramAddress: got %h want 0", ramAddress); end
    vectors++; if (read_signal !== 1'b0)  begin miscompares++; $display("FAIL reset read_signal: got %b want 0", read_signal); end
    vectors++; if (code !== 8'h00)        begin miscompares++; $display("FAIL reset code: got %h want 00", code); end
    vectors++; if (code_valid !== 1'b0)   begin miscompares++; $display("FAIL reset code_valid: got %b want 0", code_valid); end
    vectors++; if (busy !== 1'b0)         begin miscompares++; $display("FAIL reset busy: got %b want 0", busy); end
    vectors++; if (done !== 1'b0)         begin miscompares++; $display("FAIL reset done: got %b want 0", done); end
    vectors++; if (codeCount !== 16'd0)   begin miscompares++; $display("FAIL reset codeCount: got %0d want 0", codeCount); end
    RST = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_single_run();
    int c0 = codeIdx;
    mem[8'h10] = 8'hFF; mem[8'h11] = 8'hFF;
    do_start(16'h0010, 16'd2);
    vectors++; if (busy !== 1'b1)        begin miscompares++; $display("FAIL ff busy after start: got %b want 1", busy); end
    vectors++; if (read_signal !== 1'b0) begin miscompares++; $display("FAIL ff read_signal at 1 cycle: got %b want 0", read_signal); end
    @(negedge clk);
    vectors++; if (read_signal !== 1'b1) begin miscompares++; $display("FAIL ff read_signal at 2 cycles: got %b want 1", read_signal); end
    vectors++; if (ramAddress !== 16'h0010) begin miscompares++; $display("FAIL ff ramAddress: got %h want 0010", ramAddress); end
    wait_done("ff", 200);
    vectors++; if (busy !== 1'b0)        begin miscompares++; $display("FAIL ff busy at done: got %b want 0", busy); end
    vectors++; if (codeCount !== 16'd1)  begin miscompares++; $display("FAIL ff codeCount: got %0d want 1", codeCount); end
    vectors++; if (codeIdx - c0 != 1)    begin miscompares++; $display("FAIL ff codes seen: got %0d want 1", codeIdx - c0); end
    vectors++; if (codeLog[c0 % 64] !== 8'h90) begin miscompares++; $display("FAIL ff code0: got %h want 90", codeLog[c0 % 64]); end
    @(negedge clk);
    vectors++; if (done !== 1'b0)        begin miscompares++; $display("FAIL ff done width: got %b want 0", done); end
  endtask

  task automatic test_split_and_busy_start();
    int c0 = codeIdx;
    int a0 = addrIdx;
    bit [7:0] expc [2] = '{8'h84, 8'h04};
    mem[8'h20] = 8'hF0;
    do_start(16'h0020, 16'd1);
    @(negedge clk);
    do_start(16'h0090, 16'd5);
    wait_done("f0", 200);
    vectors++; if (codeCount !== 16'd2) begin miscompares++; $display("FAIL f0 codeCount: got %0d want 2", codeCount); end
    vectors++; if (codeIdx - c0 != 2)   begin miscompares++; $display("FAIL f0 codes seen: got %0d want 2", codeIdx - c0); end
    for (int i = 0; i < 2; i++) begin
      vectors++;
      if (codeLog[(c0 + i) % 64] !== expc[i]) begin
        miscompares++; $display("FAIL f0 code%0d: got %h want %h", i, codeLog[(c0 + i) % 64], expc[i]);
      end
    end
    vectors++; if (addrIdx - a0 != 1)   begin miscompares++; $display("FAIL f0 reads issued: got %0d want 1", addrIdx - a0); end
    vectors++; if (addrLog[a0 % 64] !== 16'h0020) begin miscompares++; $display("FAIL f0 read addr: got %h want 0020", addrLog[a0 % 64]); end
  endtask

  task automatic test_max_run();
    int c0 = codeIdx;
    bit [7:0] expc [2] = '{8'h7F, 8'h01};
    for (int i = 8'h30; i < 8'h40; i++) mem[i] = 8'h00;
    do_start(16'h0030, 16'd16);
    wait_done("maxrun", 1000);
    vectors++; if (codeCount !== 16'd2) begin miscompares++; $display("FAIL maxrun codeCount: got %0d want 2", codeCount); end
    vectors++; if (codeIdx - c0 != 2)   begin miscompares++; $display("FAIL maxrun codes seen: got %0d want 2", codeIdx - c0); end
    for (int i = 0; i < 2; i++) begin
      vectors++;
      if (codeLog[(c0 + i) % 64] !== expc[i]) begin
        miscompares++; $display("FAIL maxrun code%0d: got %h want %h", i, codeLog[(c0 + i) % 64], expc[i]);
      end
    end
  endtask

  task automatic test_stall();
    int c0 = codeIdx;
    int e0 = stableErr;
    bit [7:0] want;
    mem[8'h40] = 8'hAA;
    stallLen = 5;
    do_start(16'h0040, 16'd1);
    wait_done("stall", 500);
    stallLen = 0;
    vectors++; if (codeCount !== 16'd8) begin miscompares++; $display("FAIL stall codeCount: got %0d want 8", codeCount); end
    vectors++; if (codeIdx - c0 != 8)   begin miscompares++; $display("FAIL stall codes seen: got %0d want 8", codeIdx - c0); end
    for (int i = 0; i < 8; i++) begin
      want = (i % 2 == 0) ? 8'h81 : 8'h01;
      vectors++;
      if (codeLog[(c0 + i) % 64] !== want) begin
        miscompares++; $display("FAIL stall code%0d: got %h want %h", i, codeLog[(c0 + i) % 64], want);
      end
    end
    vectors++; if (stableErr - e0 != 0) begin miscompares++; $display("FAIL stall hold: %0d unstable cycles, want 0", stableErr - e0); end
  endtask

  task automatic test_dma_delay();
    int c0 = codeIdx;
    int e0 = addrErr;
    bit [7:0] expc [3] = '{8'h02, 8'h84, 8'h02};
    mem[8'h50] = 8'h3C;
    dmaLat = 3;
    do_start(16'h0050, 16'd1);
    @(negedge clk);
    for (int k = 0; k < 4; k++) begin
      vectors++; if (read_signal !== 1'b1) begin miscompares++; $display("FAIL delay read_signal cyc%0d: got %b want 1", k, read_signal); end
      vectors++; if (ramAddress !== 16'h0050) begin miscompares++; $display("FAIL delay ramAddress cyc%0d: got %h want 0050", k, ramAddress); end
      @(negedge clk);
    end
    wait_done("delay", 200);
    dmaLat = 0;
    vectors++; if (addrErr - e0 != 0)   begin miscompares++; $display("FAIL delay addr drift: got %0d want 0", addrErr - e0); end
    vectors++; if (codeCount !== 16'd3) begin miscompares++; $display("FAIL delay codeCount: got %0d want 3", codeCount); end
    for (int i = 0; i < 3; i++) begin
      vectors++;
      if (codeLog[(c0 + i) % 64] !== expc[i]) begin
        miscompares++; $display("FAIL delay code%0d: got %h want %h", i, codeLog[(c0 + i) % 64], expc[i]);
      end
    end
  endtask

  task automatic test_zero_count();
    int c0 = codeIdx;
    int a0 = addrIdx;
    do_start(16'h0060, 16'd0);
    vectors++; if (done !== 1'b0)       begin miscompares++; $display("FAIL zero done early: got %b want 0", done); end
    @(negedge clk);
    vectors++; if (done !== 1'b1)       begin miscompares++; $display("FAIL zero done: got %b want 1", done); end
    vectors++; if (busy !== 1'b0)       begin miscompares++; $display("FAIL zero busy: got %b want 0", busy); end
    vectors++; if (codeCount !== 16'd0) begin miscompares++; $display("FAIL zero codeCount: got %0d want 0", codeCount); end
    @(negedge clk);
    vectors++; if (done !== 1'b0)       begin miscompares++; $display("FAIL zero done width: got %b want 0", done); end
    vectors++; if (codeIdx != c0 || code_valid !== 1'b0) begin miscompares++; $display("FAIL zero codes: got %0d want 0", codeIdx - c0); end
    vectors++; if (addrIdx != a0)       begin miscompares++; $display("FAIL zero reads: got %0d want 0", addrIdx - a0); end
  endtask

  task automatic test_wrap();
    int c0 = codeIdx;
    int a0 = addrIdx;
    bit [7:0] expc [2] = '{8'h04, 8'h8C};
    mem[8'hFF] = 8'h0F; mem[8'h00] = 8'hFF;
    do_start(16'hFFFF, 16'd2);
    wait_done("wrap", 300);
    vectors++; if (addrLog[a0 % 64] !== 16'hFFFF)       begin miscompares++; $display("FAIL wrap addr0: got %h want FFFF", addrLog[a0 % 64]); end
    vectors++; if (addrLog[(a0 + 1) % 64] !== 16'h0000) begin miscompares++; $display("FAIL wrap addr1: got %h want 0000", addrLog[(a0 + 1) % 64]); end
    vectors++; if (codeCount !== 16'd2) begin miscompares++; $display("FAIL wrap codeCount: got %0d want 2", codeCount); end
    for (int i = 0; i < 2; i++) begin
      vectors++;
      if (codeLog[(c0 + i) % 64] !== expc[i]) begin
        miscompares++; $display("FAIL wrap code%0d: got %h want %h", i, codeLog[(c0 + i) % 64], expc[i]);
      end
    end
  endtask

  task automatic test_reset_mid();
    int n = 0;
    int c0;
    bit [7:0] expc [3] = '{8'h82, 8'h04, 8'h82};
    mem[8'h70] = 8'h0F;
    stallLen = 100;
    do_start(16'h0070, 16'd1);
    while (code_valid !== 1'b1 && n < 100) begin
      @(negedge clk);
      n++;
    end
    vectors++; if (code_valid !== 1'b1) begin miscompares++; $display("FAIL rstmid emit: code_valid %b want 1", code_valid); end
    RST = 1'b1;
    @(negedge clk);
    RST = 1'b0;
    vectors++; if (code_valid !== 1'b0)  begin miscompares++; $display("FAIL rstmid code_valid: got %b want 0", code_valid); end
    vectors++; if (code !== 8'h00)       begin miscompares++; $display("FAIL rstmid code: got %h want 00", code); end
    vectors++; if (busy !== 1'b0)        begin miscompares++; $display("FAIL rstmid busy: got %b want 0", busy); end
    vectors++; if (codeCount !== 16'd0)  begin miscompares++; $display("FAIL rstmid codeCount: got %0d want 0", codeCount); end
    vectors++; if (read_signal !== 1'b0 || ramAddress !== '0 || done !== 1'b0) begin
      miscompares++; $display("FAIL rstmid dma/done: got rs=%b addr=%h done=%b want 0", read_signal, ramAddress, done);
    end
    stallLen = 0;
    @(negedge clk);
    c0 = codeIdx;
    mem[8'h80] = 8'hC3;
    do_start(16'h0080, 16'd1);
    wait_done("rstmid-after", 200);
    vectors++; if (codeCount !== 16'd3) begin miscompares++; $display("FAIL rstmid-after codeCount: got %0d want 3", codeCount); end
    for (int i = 0; i < 3; i++) begin
      vectors++;
      if (codeLog[(c0 + i) % 64] !== expc[i]) begin
        miscompares++; $display("FAIL rstmid-after code%0d: got %h want %h", i, codeLog[(c0 + i) % 64], expc[i]);
      end
    end
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: time limit reached");
    $fatal(1);
  end

  initial begin
    RST = 1'b1; start = 1'b0; baseAddr = '0; byteCount = '0;
    for (int i = 0; i < 256; i++) mem[i] = 8'h00;
    test_reset();
    test_single_run();
    test_split_and_busy_start();
    test_max_run();
    test_stall();
    test_dma_delay();
    test_zero_count();
    test_wrap();
    test_reset_mid();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/compress_handler.md
Name: compress_handler

Overview:
- Read-side counterpart of the decompression path: reads a raw bitmap from RAM through the DMA read port and run-length encodes the bits, MSB-first.
- Emits one 8-bit code per handshake in the format the decompressor consumes: bit7 = bit value, bits6:0 = run length (1..127).
- Sits between the DMA module and the outbound code stream/serializer.

Parameters:
- ADDR_W, 16, RAM address width
- MAX_RUN, 127, maximum run length per code; must be ≤127

Ports:
- clk  in  1  clock, all logic on posedge
- RST  in  1  synchronous active-high reset
- start  in  1  one-cycle request to begin; ignored while busy
- baseAddr  in  ADDR_W  first RAM byte address, latched on start
- byteCount  in  16  number of bytes to compress, latched on start
- ramAddress  out  ADDR_W  DMA read address
- read_signal  out  1  DMA read request
- ramDataOut  in  8  DMA read data, valid when doneRead=1
- doneRead  in  1  DMA read-complete pulse
- code  out  8  {bitValue, runLen[6:0]}
- code_valid  out  1  code available
- code_ready  in  1  consumer accepts code
- busy  out  1  high from the cycle after start until done
- done  out  1  one-cycle completion pulse
- codeCount  out  16  codes emitted in the current/last job; cleared on start

Behaviour:
- Reset: all outputs 0; FSM → IDLE; run state cleared. Reset mid-operation aborts immediately; a pending DMA read is abandoned and a later doneRead is ignored in IDLE.
- FSM states: IDLE, REQ, WAIT, SCAN, EMIT, FLUSH, FIN.
- IDLE:
  - On start with byteCount>0: latch address/count, clear codeCount, set busy, go to REQ.
  - On start with byteCount==0: go to FIN; no codes emitted.
- REQ: drive ramAddress = baseAddr + byteIdx, read_signal=1; go to WAIT.
- WAIT:
  - Hold read_signal=1 and ramAddress stable until doneRead.
  - On doneRead: capture ramDataOut into the shift register, drop read_signal, set bitPtr=7, go to SCAN.
- SCAN: consume one bit per cycle, bit[bitPtr].
  - First bit of the job: curBit=b, runLen=1.
  - b==curBit and runLen<MAX_RUN: runLen++.
  - Otherwise: code<={curBit,runLen}, code_valid<=1, curBit<=b, runLen<=1, go to EMIT.
  - After bitPtr==0:
    - more bytes remain: byteIdx++, go to REQ (if not already going to EMIT);
    - last byte: go to FLUSH.
- EMIT:
  - code and code_valid are held stable until code_valid&&code_ready.
  - On that cycle: drop code_valid, codeCount++.
  - Return to SCAN if bits remain in the current byte; otherwise REQ (more bytes) or FLUSH (last byte).
- FLUSH:
  - Present the final run {curBit,runLen} with code_valid=1.
  - On handshake: codeCount++, go to FIN.
- FIN: done=1 for one cycle, busy=0, go to IDLE.
- Invariants:
  - code_valid never drops without a handshake.
  - Runs never span MAX_RUN; a run reaching exactly MAX_RUN is emitted when the next bit arrives, or at FLUSH.
  - Runs span byte boundaries.
  - The sum of runLen over all codes equals 8*byteCount.
- Latency:
  - start → read_signal asserted after 2 cycles.
  - Unstalled throughput: 1 bit/cycle, plus DMA latency per byte and 1 cycle per emitted code.
- ramAddress wraps modulo 2^ADDR_W.
- start during busy has no effect.

Test Plan:
- bytes {0xFF,0xFF}, code_ready=1 → single code 0x90 (bit 1, run 16); codeCount=1; done pulse.
- byte {0xF0} → codes 0x84 then 0x04; codeCount=2.
- 16 bytes of 0x00 (128 zeros) → codes 0x7F then 0x01; checks MAX_RUN split.
- byte {0xAA}, code_ready low for 5 cycles per code → 8 codes alternating 0x81/0x01; code stable while stalled.
- doneRead delayed 3 cycles → read_signal and ramAddress held stable; byteCount=0 → done one cycle after FIN entry, no code_valid.
- RST asserted during EMIT → next cycle all outputs 0, IDLE; new start then compresses correctly.
